resp_capture_checker: RTL

RESP_CAPTURE_CHECKER -- requirements
Module: resp_capture_checker

---
 rtl/resp_capture_checker_pkg.sv | 16 +
 rtl/resp_capture_checker_if.sv | 33 +++
 rtl/resp_capture_checker.sv | 84 ++++++++
 3 files changed

// File: rtl/resp_capture_checker_pkg.sv
// Shared definitions for the response capture checker.
//   N_IN   : width of the pattern index
//   N_PAT  : number of patterns per run (2**N_IN)
//   state_t: run-control FSM states
package resp_capture_checker_pkg;

    localparam int N_IN  = 5;
    localparam int N_PAT = 2 ** N_IN;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/resp_capture_checker_if.sv
// Stimulus/response bundle between a pattern source and the capture checker.
//   start, pat_valid, pat, dut_out, golden : source -> checker
//   busy, done, mismatch, seq_err,
//   first_fail, fail_count, signature      : checker -> source
// master = pattern source / bench side, slave = checker side.
interface resp_capture_checker_if;
    import resp_capture_checker_pkg::*;

    logic             start;
    logic             pat_valid;
    logic [N_IN-1:0]  pat;
    logic             dut_out;
    logic [N_PAT-1:0] golden;

    logic             busy;
    logic             done;
    logic             mismatch;
    logic             seq_err;
    logic [N_IN-1:0]  first_fail;
    logic [N_IN:0]    fail_count;
    logic [N_PAT-1:0] signature;

    modport master (
        output start, pat_valid, pat, dut_out, golden,
        input  busy, done, mismatch, seq_err, first_fail, fail_count, signature
    );

    modport slave (
        input  start, pat_valid, pat, dut_out, golden,
        output busy, done, mismatch, seq_err, first_fail, fail_count, signature
    );

endinterface

// File: rtl/resp_capture_checker.sv
// Captures one single-bit DUT response per pattern index over a run of N_PAT
// samples, compares each against a golden vector and reports a signature,
// mismatch/sequence flags, the first failing index and a failure count.
// Ports:
//   CK    : clock, rising edge
//   reset : synchronous active-low reset
//   bus   : resp_capture_checker_if.slave (stimulus in, results out)
module resp_capture_checker
    import resp_capture_checker_pkg::*;
(
    input  logic                   CK,
    input  logic                   reset,
    resp_capture_checker_if.slave  bus
);

    localparam logic [N_IN-1:0] LAST_IDX = '1;
    localparam logic [N_IN:0]   FC_MAX   = (N_IN+1)'(N_PAT);

    state_t           state;
    logic [N_IN-1:0]  exp_idx;
    logic             mismatch;
    logic             seq_err;
    logic [N_IN-1:0]  first_fail;
    logic [N_IN:0]    fail_count;
    logic [N_PAT-1:0] signature;

    always_ff @(posedge CK) begin
        if (!reset) begin
            state      <= IDLE;
            exp_idx    <= '0;
            mismatch   <= 1'b0;
            seq_err    <= 1'b0;
            first_fail <= '0;
            fail_count <= '0;
            signature  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state      <= CAPTURE;
                        exp_idx    <= '0;
                        mismatch   <= 1'b0;
                        seq_err    <= 1'b0;
                        first_fail <= '0;
                        fail_count <= '0;
                        signature  <= '0;
                    end
                end
                CAPTURE: begin
                    if (bus.pat_valid) begin
                        // Out-of-order samples are flagged but still stored by
                        // their own index, not by the expected one.
                        signature[bus.pat] <= bus.dut_out;
                        if (bus.pat != exp_idx)
                            seq_err <= 1'b1;
                        if (bus.dut_out != bus.golden[bus.pat]) begin
                            mismatch <= 1'b1;
                            if (fail_count == '0)
                                first_fail <= bus.pat;
                            if (fail_count != FC_MAX)
                                fail_count <= fail_count + 1'b1;
                        end
                        // Run length is counted in samples, independent of
                        // which indices actually arrived.
                        if (exp_idx == LAST_IDX)
                            state <= DONE;
                        exp_idx <= exp_idx + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy       = (state == CAPTURE);
    assign bus.done       = (state == DONE);
    assign bus.mismatch   = mismatch;
    assign bus.seq_err    = seq_err;
    assign bus.first_fail = first_fail;
    assign bus.fail_count = fail_count;
    assign bus.signature  = signature;

endmodule
